// File: rtl/vec_mult_pipe.sv
// Pipelined valid/ready slot-wise vector multiplier with signed/unsigned beats.
// Optional multiply-accumulate final stage enabled by defining VEC_MULT_MAC_EN.
`ifndef W_BITS
`define W_BITS 8
`endif
`ifndef N_SLOTS
`define N_SLOTS 4
`endif

module vec_mult_pipe #(
  parameter int W      = `W_BITS,
  parameter int N      = `N_SLOTS,
  parameter int STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*W-1:0]           in_a,
  input  logic [N*W-1:0]           in_b,
  input  logic                     in_signed,
  input  logic                     in_acc,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*(2*W+1)-1:0]     out_data
);

  localparam int PW = 2*W+1;
  localparam int OW = N*W;

`ifdef VEC_MULT_MAC_EN
  localparam int FW = 3;
`else
  localparam int FW = 1;
`endif

  localparam int BW = 2*OW + FW;

  logic          adv;
  logic [FW-1:0] in_fl;
  logic [BW-1:0] in_beat;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !reset;

`ifdef VEC_MULT_MAC_EN
  assign in_fl = {in_last, in_acc, in_signed};
`else
  logic unused_flags;
  assign in_fl        = in_signed;
  assign unused_flags = ^{in_acc, in_last};
`endif

  assign in_beat = {in_fl, in_b, in_a};

  // Final-stage view of the beat: delayed STAGES-1 times
  logic          f_v;
  logic [BW-1:0] f_d;

  if (STAGES > 1) begin : g_pipe
    logic          v_q [STAGES-1];
    logic [BW-1:0] d_q [STAGES-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < STAGES-1; k++)
          v_q[k] <= 1'b0;
      end else if (adv) begin
        v_q[0] <= in_valid;
        d_q[0] <= in_beat;
        for (int k = 1; k < STAGES-1; k++) begin
          v_q[k] <= v_q[k-1];
          d_q[k] <= d_q[k-1];
        end
      end
    end

    assign f_v = v_q[STAGES-2];
    assign f_d = d_q[STAGES-2];
  end else begin : g_bypass
    assign f_v = in_valid;
    assign f_d = in_beat;
  end

  logic [OW-1:0] f_a;
  logic [OW-1:0] f_b;
  logic          f_sg;

  assign f_a  = f_d[OW-1:0];
  assign f_b  = f_d[2*OW-1:OW];
  assign f_sg = f_d[2*OW];

  // Extending both operands to PW bits makes the truncated product
  // equal the sign/zero-extended 2W-bit product.
  function automatic logic [PW-1:0] mul(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         sg
  );
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    ea = {{(W+1){sg & a[W-1]}}, a};
    eb = {{(W+1){sg & b[W-1]}}, b};
    return ea * eb;
  endfunction

  logic [N*PW-1:0] prod;

  always_comb begin
    prod = '0;
    for (int i = 0; i < N; i++)
      prod[i*PW +: PW] = mul(f_a[i*W +: W], f_b[i*W +: W], f_sg);
  end

  logic            out_valid_q;
  logic [N*PW-1:0] out_data_q;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef VEC_MULT_MAC_EN
  logic            f_acc;
  logic            f_last;
  logic [N*PW-1:0] acc_q;
  logic [N*PW-1:0] acc_d;

  assign f_acc  = f_d[2*OW+1];
  assign f_last = f_d[2*OW+2];

  always_comb begin
    acc_d = '0;
    for (int i = 0; i < N; i++)
      acc_d[i*PW +: PW] = f_acc ? acc_q[i*PW +: PW] + prod[i*PW +: PW]
                                : prod[i*PW +: PW];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      acc_q       <= '0;
    end else if (adv) begin
      out_valid_q <= f_v && f_last;
      if (f_v)
        acc_q <= acc_d;
      if (f_v && f_last)
        out_data_q <= acc_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (adv) begin
      out_valid_q <= f_v;
      if (f_v)
        out_data_q <= prod;
    end
  end
`endif

endmodule

// File: tb/tb_vec_mult_pipe.sv
// Testbench for vec_mult_pipe: vector table, backpressure, MAC and reset.
// Expected outputs flow through a scoreboard queue checked on handshake.
module tb_vec_mult_pipe;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int ST = 2;
  localparam int PW = 2*W+1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*W-1:0]  in_a = '0;
  logic [N*W-1:0]  in_b = '0;
  logic            in_signed = 1'b0;
  logic            in_acc = 1'b0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [N*PW-1:0] out_data;

  always #5 clk = ~clk;

  vec_mult_pipe #(.W(W), .N(N), .STAGES(ST)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  typedef struct {
    logic [N*PW-1:0] d;
    int              cyc;
    bit              chk;
  } exp_t;

  typedef struct {
    logic [N*W-1:0]  a;
    logic [N*W-1:0]  b;
    bit              sg;
    bit              acc;
    bit              last;
    bit              emit;
    logic [N*PW-1:0] exp;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N*W-1:0] rep8(input logic [W-1:0] x);
    return {N{x}};
  endfunction

  function automatic logic [N*PW-1:0] rep17(input logic [PW-1:0] x);
    return {N{x}};
  endfunction

  task automatic chk(input string nm, input logic [N*PW-1:0] act,
                     input logic [N*PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input vec_t v, input bit lat);
    int n;
    @(negedge clk);
    in_a = v.a; in_b = v.b;
    in_signed = v.sg; in_acc = v.acc; in_last = v.last;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end else if (v.emit) begin
      sb.push_back('{v.exp, cyc + ST, lat});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Handshake monitor and stall-stability check
  bit              prev_stall = 1'b0;
  logic [N*PW-1:0] prev_d = '0;

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (prev_stall) begin
        n_cmp++;
        if (!out_valid || out_data !== prev_d) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h",
                   out_valid, out_data, prev_d);
        end
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_out: got %h want none", out_data);
        end else begin
          mon_e = sb.pop_front();
          chk("out_data", out_data, mon_e.d);
          if (mon_e.chk)
            chk("latency", cyc, mon_e.cyc);
        end
      end
    end
    prev_stall = out_valid && !out_ready && !reset;
    prev_d     = out_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  vec_t tbl[6];
  vec_t mac[3];
  vec_t v;
  int   outs0;

  initial begin
    tbl[0] = '{rep8(8'hFF), rep8(8'hFF), 1'b0, 1'b0, 1'b1, 1'b1,
               rep17(17'h0FE01)};
    tbl[1] = '{{8'h00, 8'h7F, 8'hFF, 8'h80}, {8'hFB, 8'h80, 8'h01, 8'h80},
               1'b1, 1'b0, 1'b1, 1'b1,
               {17'h00000, 17'h1C080, 17'h1FFFF, 17'h04000}};
    tbl[2] = '{{8'd200, 8'd255, 8'd1, 8'd0}, {8'd3, 8'd1, 8'd255, 8'd77},
               1'b0, 1'b0, 1'b1, 1'b1,
               {17'h00258, 17'h000FF, 17'h000FF, 17'h00000}};
    tbl[3] = '{{8'd200, 8'd255, 8'd1, 8'd0}, {8'd3, 8'd1, 8'd255, 8'd77},
               1'b1, 1'b0, 1'b1, 1'b1,
               {17'h1FF58, 17'h1FFFF, 17'h1FFFF, 17'h00000}};
    tbl[4] = '{rep8(8'h80), rep8(8'h80), 1'b0, 1'b0, 1'b1, 1'b1,
               rep17(17'h04000)};
    tbl[5] = '{rep8(8'h7F), rep8(8'h7F), 1'b1, 1'b0, 1'b1, 1'b1,
               rep17(17'h03F01)};

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, '0);
    chk("rst_out_valid", out_valid, '0);
    chk("rst_out_data", out_data, '0);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back table stream with latency check
    for (int i = 0; i < 6; i++)
      send(tbl[i], 1'b1);
    idle();
    drain();

    // Backpressure: 6 beats, out_ready low for 5 cycles
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          v = '{rep8(W'(i)), rep8(W'(i+1)), 1'b0, 1'b0, 1'b1, 1'b1,
                rep17(PW'(i*(i+1)))};
          send(v, 1'b0);
        end
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("bp_in_ready", in_ready, '0);
        chk("bp_out_valid", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // MAC reduction sequence
`ifdef VEC_MULT_MAC_EN
    mac[0] = '{rep8(8'd3), rep8(8'd4), 1'b0, 1'b0, 1'b0, 1'b0, '0};
    mac[1] = '{rep8(8'd5), rep8(8'd6), 1'b0, 1'b1, 1'b0, 1'b0, '0};
    mac[2] = '{rep8(8'd7), rep8(8'd1), 1'b0, 1'b1, 1'b1, 1'b1,
               rep17(17'd49)};
`else
    mac[0] = '{rep8(8'd3), rep8(8'd4), 1'b0, 1'b0, 1'b0, 1'b1,
               rep17(17'd12)};
    mac[1] = '{rep8(8'd5), rep8(8'd6), 1'b0, 1'b1, 1'b0, 1'b1,
               rep17(17'd30)};
    mac[2] = '{rep8(8'd7), rep8(8'd1), 1'b0, 1'b1, 1'b1, 1'b1,
               rep17(17'd7)};
`endif
    outs0 = n_out;
    for (int i = 0; i < 3; i++)
      send(mac[i], 1'b1);
    idle();
    drain();
`ifdef VEC_MULT_MAC_EN
    chk("mac_out_count", n_out - outs0, 1);
`else
    chk("mac_out_count", n_out - outs0, 3);
`endif

    // Reset mid-stream discards two in-flight beats
    out_ready = 1'b0;
    v = '{rep8(8'd9), rep8(8'd9), 1'b0, 1'b0, 1'b1, 1'b0, '0};
    send(v, 1'b0);
    send(v, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, '0);
    chk("mid_rst_out_data", out_data, '0);
    out_ready = 1'b1;
    outs0 = n_out;
    v = '{rep8(8'd2), rep8(8'd3), 1'b0, 1'b1, 1'b1, 1'b1, rep17(17'd6)};
    send(v, 1'b1);
    idle();
    drain();
    chk("post_rst_out_count", n_out - outs0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
